// File: rtl/steppers_pkg.sv
// Shared stepper/encoder definitions: quadrature phase encoding and defaults.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package steppers_pkg;

  // Default geometry, shared by the encoder emulator and the counting logic.
  localparam int N_ENC_DEF   = 400;
  localparam int N_STEPS_DEF = 800;

  // Gray-coded {A,B} quadrature phase; forward order is 00 -> 01 -> 11 -> 10.
  typedef enum logic [1:0] {
    QPH_00 = 2'b00,
    QPH_01 = 2'b01,
    QPH_11 = 2'b11,
    QPH_10 = 2'b10
  } qphase_t;

  // One quadrature step from ph, forward when fwd=1, otherwise backward.
  function automatic qphase_t next_phase(input logic fwd, input qphase_t ph);
    qphase_t nxt;
    case (ph)
      QPH_00:  nxt = fwd ? QPH_01 : QPH_10;
      QPH_01:  nxt = fwd ? QPH_11 : QPH_00;
      QPH_11:  nxt = fwd ? QPH_10 : QPH_01;
      default: nxt = fwd ? QPH_00 : QPH_11;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/step_to_quad_encoder_if.sv
// Pin bundle between the step/dir driver side and the emulated encoder outputs.
// Latency: n/a (wires only).
// Backpressure: none; step/dir are free-running pins, outputs are levels.
interface step_to_quad_encoder_if;

  logic step;
  logic dir;
  logic enc_a;
  logic enc_b;
  logic enc_i;
  logic busy;
  logic overrun;

  // Driver side: produces step/dir, observes the encoder pins.
  modport master (
    output step,
    output dir,
    input  enc_a,
    input  enc_b,
    input  enc_i,
    input  busy,
    input  overrun
  );

  // Emulator side: consumes step/dir, produces the encoder pins.
  modport slave (
    input  step,
    input  dir,
    output enc_a,
    output enc_b,
    output enc_i,
    output busy,
    output overrun
  );

endinterface

// File: rtl/step_to_quad_encoder_sync_rise.sv
// Two-flop synchronizer for an asynchronous pin plus a rising-edge detector.
// Latency: level valid 2 clk after the pin; rise is combinational off the level.
// Backpressure: none.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic last;

  // Metastability chain plus one extra stage to remember the previous level.
  // Reset clears everything, so a pin held high across reset re-arms as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      last <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      last <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~last;

endmodule

// File: rtl/step_to_quad_encoder.sv
// Regenerates encoder quadrature A/B/index from stepper step/dir pins.
// Latency: 4 clk from the first edge sampling step high to the first A/B change.
// Backpressure: none; steps beyond the edge backlog are dropped and flag overrun.
module step_to_quad_encoder
  import steppers_pkg::*;
#(
  parameter int N_ENC    = N_ENC_DEF,
  parameter int N_STEPS  = N_STEPS_DEF,
  parameter int MIN_EDGE = 4,
  parameter int BACKLOG  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  step_to_quad_encoder_if.slave bus
);

  localparam int QPR    = 4 * N_ENC;
  localparam int ACC_W  = $clog2((BACKLOG + 1) * N_STEPS + QPR) + 1;
  localparam int QPOS_W = $clog2(QPR);
  localparam int GAP_W  = $clog2(MIN_EDGE);

  localparam logic signed [ACC_W-1:0] QPR_S     = ACC_W'(QPR);
  localparam logic signed [ACC_W-1:0] N_STEPS_S = ACC_W'(N_STEPS);
  localparam logic signed [ACC_W-1:0] LIM_S     = ACC_W'(BACKLOG * N_STEPS);
  localparam logic [QPOS_W-1:0]       QPOS_MAX  = QPOS_W'(QPR - 1);
  localparam logic [GAP_W-1:0]        GAP_LOAD  = GAP_W'(MIN_EDGE - 1);

  // Synchronized pins.
  logic step_level_unused;
  logic step_rise;
  logic dir_level;
  logic dir_rise_unused;

  sync_rise u_sync_step (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.step),
    .level (step_level_unused),
    .rise  (step_rise)
  );

  sync_rise u_sync_dir (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.dir),
    .level (dir_level),
    .rise  (dir_rise_unused)
  );

  // Architectural state.
  // acc holds (steps * QPR) - (qpos * N_STEPS); it is the fractional backlog
  // of quadrature edges scaled by N_STEPS, so the step/encoder ratio need not
  // be an integer.
  logic signed [ACC_W-1:0]  acc;
  logic [QPOS_W-1:0]        qpos;
  qphase_t                  phase;
  logic [GAP_W-1:0]         gap;
  logic                     enc_i_q;
  logic                     overrun_q;

  // Next-state values.
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  step_delta;
  logic signed [ACC_W-1:0]  acc_stepped;
  logic                     step_ok;
  logic [QPOS_W-1:0]        qpos_next;
  qphase_t                  phase_next;
  logic [GAP_W-1:0]         gap_next;
  logic                     enc_i_next;
  logic                     overrun_next;

  // Emitter decision terms, all from registered state.
  logic gap_expired;
  logic acc_neg;
  logic acc_ready;
  logic fwd_edge;
  logic rev_edge;

  assign gap_expired = (gap == '0);
  assign acc_neg     = acc[ACC_W-1];
  assign acc_ready   = !acc_neg && (acc >= N_STEPS_S);
  assign fwd_edge    = gap_expired && acc_ready;
  assign rev_edge    = gap_expired && acc_neg;

  // Step intake, edge emission and position tracking for the next cycle.
  // The overrun bound is judged on the step delta alone, so whether an emit
  // happens in the same cycle never decides if a step is kept.
  always_comb begin
    step_delta   = '0;
    acc_stepped  = acc;
    step_ok      = 1'b0;
    acc_next     = acc;
    qpos_next    = qpos;
    phase_next   = phase;
    gap_next     = gap;
    enc_i_next   = enc_i_q;
    overrun_next = overrun_q;

    if (step_rise) begin
      step_delta = dir_level ? QPR_S : -QPR_S;
    end
    acc_stepped = acc + step_delta;
    step_ok     = step_rise && (acc_stepped <= LIM_S) && (acc_stepped >= -LIM_S);

    if (step_ok) begin
      acc_next = acc_stepped;
    end
    if (step_rise && !step_ok) begin
      overrun_next = 1'b1;
    end

    if (fwd_edge) begin
      acc_next   = acc_next - N_STEPS_S;
      phase_next = next_phase(1'b1, phase);
      qpos_next  = (qpos == QPOS_MAX) ? '0 : qpos + QPOS_W'(1);
    end else if (rev_edge) begin
      acc_next   = acc_next + N_STEPS_S;
      phase_next = next_phase(1'b0, phase);
      qpos_next  = (qpos == '0) ? QPOS_MAX : qpos - QPOS_W'(1);
    end

    // The gap timer restarts on every emitted edge and counts down to expiry.
    if (fwd_edge || rev_edge) begin
      gap_next = GAP_LOAD;
    end else if (!gap_expired) begin
      gap_next = gap - GAP_W'(1);
    end

    // Index is registered off the next position so it moves with A/B.
    enc_i_next = (qpos_next == '0);
  end

  // State register; reset drops any pending backlog on the spot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      qpos      <= '0;
      phase     <= QPH_00;
      gap       <= '0;
      enc_i_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      acc       <= acc_next;
      qpos      <= qpos_next;
      phase     <= phase_next;
      gap       <= gap_next;
      enc_i_q   <= enc_i_next;
      overrun_q <= overrun_next;
    end
  end

  assign bus.enc_a   = phase[1];
  assign bus.enc_b   = phase[0];
  assign bus.enc_i   = enc_i_q;
  assign bus.busy    = acc_ready || acc_neg;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_step_to_quad_encoder.sv
// Directed bench for the step-to-quadrature encoder emulator.
// Table of per-cycle vectors for single steps, hand sequences for bursts/reset.
// A quadrature decoder tracks position, edge count and edge spacing.
module tb_step_to_quad_encoder;

  localparam int QPR      = 1600;
  localparam int MIN_EDGE = 4;

  logic clk;
  logic rst_n;

  step_to_quad_encoder_if bus ();

  step_to_quad_encoder #(
    .N_ENC    (400),
    .N_STEPS  (800),
    .MIN_EDGE (MIN_EDGE),
    .BACKLOG  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Decoder / monitor state (written only by the monitor process).
  logic [1:0] prev_ab = 2'b00;
  int pos      = 0;
  int edges    = 0;
  int since    = 100;
  int sp_viol  = 0;
  int illegal  = 0;
  int idx_bad  = 0;

  function automatic logic [1:0] fwd_of(input logic [1:0] ab);
    logic [1:0] r;
    case (ab)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Quadrature decoder and spacing/index monitor, sampled at the falling edge.
  always @(negedge clk) begin
    logic [1:0] cur;
    cur = {bus.enc_a, bus.enc_b};
    if (!rst_n) begin
      prev_ab = 2'b00;
      pos     = 0;
      since   = 100;
    end else begin
      if (since < 100) since = since + 1;
      if (cur != prev_ab) begin
        edges = edges + 1;
        if (since < MIN_EDGE) sp_viol = sp_viol + 1;
        since = 0;
        if (cur == fwd_of(prev_ab))      pos = (pos + 1) % QPR;
        else if (prev_ab == fwd_of(cur)) pos = (pos + QPR - 1) % QPR;
        else                             illegal = illegal + 1;
        prev_ab = cur;
      end
      if (bus.enc_i != (pos == 0)) idx_bad = idx_bad + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the n-th next falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // One step pulse: 2 cycles high, 2 low, direction held throughout.
  task automatic step_pulse(input logic d);
    bus.dir  = d;
    bus.step = 1'b1;
    tick(2);
    bus.step = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  typedef struct {
    logic       rst_n;
    logic       step;
    logic       dir;
    logic [1:0] ab;
    logic       idx;
    logic       busy;
  } vec_t;

  vec_t tbl[19];

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      rst_n    = tbl[r].rst_n;
      bus.step = tbl[r].step;
      bus.dir  = tbl[r].dir;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_ab", r), int'({bus.enc_a, bus.enc_b}), int'(tbl[r].ab));
      check($sformatf("row%0d_idx", r), int'(bus.enc_i), int'(tbl[r].idx));
      check($sformatf("row%0d_busy", r), int'(bus.busy), int'(tbl[r].busy));
      tick(1);
    end
  endtask

  initial begin
    int e0;
    int b0;
    int v0;
    int n;

    // Forward step after reset: A/B moves at edge 4 and again 4 cycles later.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
    // Reset, then one reverse step: 00 -> 10 -> 11.
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0};

    rst_n    = 1'b0;
    bus.step = 1'b0;
    bus.dir  = 1'b1;
    tick(2);
    check("rst_a", int'(bus.enc_a), 0);
    check("rst_b", int'(bus.enc_b), 0);
    check("rst_i", int'(bus.enc_i), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ovr", int'(bus.overrun), 0);
    rst_n = 1'b1;
    tick(1);

    // Single forward step, then single reverse step.
    run_rows(0, 8);
    check("fwd1_pos", pos, 2);
    run_rows(9, 18);
    tick(1);
    check("rev1_pos", pos, 1598);
    check("rev1_idx", int'(bus.enc_i), 0);

    // One revolution of forward steps, one step per 20 cycles.
    do_reset();
    e0 = edges;
    b0 = idx_bad;
    for (int s = 1; s <= 800; s++) begin
      step_pulse(1'b1);
      tick(16);
      if (s == 400) begin
        check("rev_half_pos", pos, 800);
        check("rev_half_idx", int'(bus.enc_i), 0);
      end
    end
    check("rev_edges", edges - e0, 1600);
    check("rev_pos", pos, 0);
    check("rev_idx", int'(bus.enc_i), 1);
    check("rev_idx_track", idx_bad - b0, 0);
    check("rev_busy", int'(bus.busy), 0);
    check("rev_ovr", int'(bus.overrun), 0);

    // Burst every 4 cycles: steps 0..14 fit, then every other step is dropped.
    do_reset();
    v0 = sp_viol;
    for (int s = 0; s < 30; s++) begin
      step_pulse(1'b1);
      if (s == 14) check("burst_ovr_before", int'(bus.overrun), 0);
      if (s == 15) check("burst_ovr_set", int'(bus.overrun), 1);
    end
    n = 0;
    while (bus.busy && n < 400) begin
      tick(1);
      n++;
    end
    check("burst_drain_in_time", int'(n < 400), 1);
    tick(2);
    check("burst_ovr_sticky", int'(bus.overrun), 1);
    check("burst_pos", pos, 44);
    check("burst_spacing", sp_viol - v0, 0);

    // Forward then reverse 4 cycles apart: net zero.
    do_reset();
    e0 = edges;
    v0 = sp_viol;
    step_pulse(1'b1);
    step_pulse(1'b0);
    tick(20);
    check("fr_ab", int'({bus.enc_a, bus.enc_b}), 0);
    check("fr_busy", int'(bus.busy), 0);
    check("fr_pos", pos, 0);
    check("fr_idx", int'(bus.enc_i), 1);
    check("fr_edges", edges - e0, 2);
    check("fr_spacing", sp_viol - v0, 0);

    // Reset while a backlog of edges is pending.
    do_reset();
    for (int s = 0; s < 9; s++) step_pulse(1'b1);
    check("mid_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", int'(bus.enc_a), 0);
    check("mid_rst_b", int'(bus.enc_b), 0);
    check("mid_rst_i", int'(bus.enc_i), 1);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_ovr", int'(bus.overrun), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    e0 = edges;
    tick(40);
    check("post_rst_edges", edges - e0, 0);
    check("post_rst_busy", int'(bus.busy), 0);
    step_pulse(1'b1);
    tick(10);
    check("post_rst_step_edges", edges - e0, 2);
    check("post_rst_step_pos", pos, 2);

    check("illegal_transitions", illegal, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_to_quad_encoder.md
# step_to_quad_encoder

Encoder emulator for the stepper test rig: consumes the driver-side step/dir pins and regenerates the quadrature A/B/index signals a shaft encoder of `N_ENC` lines would produce for a motor of `N_STEPS` steps/rev. It is the transmit end of the encoder interface our encoder-counting LED logic receives. It allows closed-loop bring-up on the FPGA without a motor attached.

## Interface
- `N_ENC`, 400: encoder lines/rev; quadrature edges/rev `QPR` = 4·`N_ENC`.
- `N_STEPS`, 800: driver steps/rev at the configured microstep mode.
- `MIN_EDGE`, 4: minimum CLK cycles between any two A/B transitions (≥2).
- `BACKLOG`, 16: maximum pending quadrature edges before overrun.
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `step`  in  1  asynchronous step pin; rising edge = one step.
- `dir`  in  1  asynchronous direction pin; 1 = forward.
- `enc_a`, `enc_b`  out  1 each  quadrature outputs.
- `enc_i`  out  1  index; high while quadrature position = 0.
- `busy`  out  1  edges pending.
- `overrun`  out  1  sticky; a step was dropped.

## Operation
- `step`, `dir` each pass a 2-FF synchronizer. Step event = synced `step` 0→1; direction = synced `dir` in the same cycle.
- Signed accumulator `acc`. Invariant: `acc` = Σsteps·`QPR` − `qpos`·`N_STEPS`; at rest 0 ≤ `acc` < `N_STEPS`.
- Forward step: `acc` += `QPR`. Reverse step: `acc` −= `QPR`.
- Emitter, evaluated when the gap timer has expired:
  - if `acc` ≥ `N_STEPS`: forward edge, `acc` −= `N_STEPS`;
  - else if `acc` < 0: reverse edge, `acc` += `N_STEPS`.
  - Step update and emit in the same cycle apply both deltas.
- Quadrature phase: 2-bit Gray, {A,B} forward 00→01→11→10→00; reverse is the opposite sequence. One edge per emit.
- `qpos`, 0..`QPR`−1: increments on a forward edge, decrements on a reverse edge, wraps modulo `QPR`. `enc_i` = (`qpos`==0), registered.
- Overrun: a step whose update would leave `acc` outside [−`BACKLOG`·`N_STEPS`, `BACKLOG`·`N_STEPS`] is dropped. `acc` is unchanged and `overrun` is set until reset.
- `busy` = (`acc` ≥ `N_STEPS`) or (`acc` < 0).

## Timing
- Reset values: `enc_a`=0, `enc_b`=0, `enc_i`=1, `busy`=0, `overrun`=0, `acc`=0, `qpos`=0, gap timer expired, synchronizers 0.
- Latency from a step event to the first output change, counting the first CLK edge that samples `step` high as edge 1:
  - edges 1–2: synchronize;
  - edge 3: `acc` updated;
  - edge 4: first output change.
- Gap timer reloads on each edge. The next edge is allowed no earlier than `MIN_EDGE` cycles later.
- `dir` must be stable 3 CLK cycles around the step rise. Otherwise the direction is whichever value is synced at detect; there is no glitch protection.
- `RST_N` low mid-burst: all state clears immediately and pending edges are discarded. The synchronized step level is also cleared, so a `step` still high at release counts as a new event once synced.
- Widths:
  - `acc`: signed, $clog2((`BACKLOG`+1)·`N_STEPS`+`QPR`)+1 bits;
  - `qpos`: $clog2(`QPR`) bits;
  - gap timer: $clog2(`MIN_EDGE`) bits.

## Structure
- Shared package `steppers_pkg`: Gray phase constants `QPH_00/01/11/10` and the `next_phase(fwd, ph)` function. Default `N_ENC`, `N_STEPS` constants also live there, so emulator and counter agree.
- Sub-module `sync_rise`: 2-FF synchronizer with registered level and rising-edge pulse outputs, instantiated for `step` and `dir`.

## Test plan
- One forward step after reset:
  - {A,B} 00→01 at edge 4, then →11 four cycles later;
  - `qpos`=2, `acc`=0, `busy` then 0, `enc_i` falls with the first edge.
- One reverse step after reset:
  - {A,B} 00→10→11;
  - `qpos`=1598, `enc_i`=0.
- 800 forward steps, one per 20 cycles:
  - 1600 edges;
  - `qpos` returns to 0, `enc_i`=1 exactly then;
  - `enc_i`=0 at step 400 (`qpos`=800).
- Steps every 4 cycles (2 high, 2 low) × 30:
  - `overrun` sets once backlog >16 edges and stays set;
  - final `qpos` = 2·(accepted steps) mod 1600;
  - edge spacing never <4.
- Forward step and reverse step 4 cycles apart:
  - net zero;
  - outputs return to 00 with `acc`=0;
  - no spacing violation.
- `RST_N` pulled low while 10 edges are pending:
  - outputs go to reset values immediately;
  - no edges after release until a new step.
